// File: rtl/nco_pkg.sv
// Shared definitions for the multi-channel NCO: apply-FSM state codes,
// the default frequency control word and the channel-index width helper.
package nco_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        APPLY = 1'b1
    } nco_state_e;

    localparam logic [0:0]  ST_IDLE       = IDLE;
    localparam logic [0:0]  ST_APPLY      = APPLY;
    localparam logic [31:0] FCW_RESET_DEF = 32'h1000_0000;

    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/nco_multi_if.sv
// Configuration bus of nco_multi: shadow-register write handshake plus the
// apply strobe. The master drives the request side; nco_multi is the slave.
interface nco_multi_if
    import nco_pkg::*;
#(
    parameter int CH_W  = ch_w(4),
    parameter int ACC_W = 32
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch;
    logic [ACC_W-1:0] cfg_fcw;
    logic [ACC_W-1:0] cfg_poff;
    logic             cfg_apply;

    modport master (
        output cfg_valid, cfg_ch, cfg_fcw, cfg_poff, cfg_apply,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_fcw, cfg_poff, cfg_apply,
        output cfg_ready
    );
endinterface

// File: rtl/nco_channel.sv
// One NCO channel: phase accumulator, active FCW (and offset when
// NCO_PHASE_OFFSET_EN is defined) and registered square/wrap/phase outputs.
module nco_channel
    import nco_pkg::*;
#(
    parameter int               ACC_W    = 32,
    parameter int               OUT_W    = 12,
    parameter logic [ACC_W-1:0] FCW_INIT = ACC_W'(FCW_RESET_DEF)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             sync,
    input  logic             load,
    input  logic [ACC_W-1:0] fcw_new,
    input  logic [ACC_W-1:0] poff_new,
    output logic             out_clk,
    output logic             wrap,
    output logic [OUT_W-1:0] phase
);
    logic [ACC_W-1:0] acc_r;
    logic [ACC_W-1:0] fcw_act_r;
    logic [ACC_W-1:0] acc_next_s;
    logic [ACC_W-1:0] p_s;
    logic [ACC_W:0]   sum_s;
    logic             wrap_next_s;

    assign sum_s = {1'b0, acc_r} + {1'b0, fcw_act_r};

    // Next accumulator value; sync wins over enable and suppresses the carry.
    always_comb begin
        acc_next_s  = acc_r;
        wrap_next_s = 1'b0;
        if (sync) begin
            acc_next_s  = {ACC_W{1'b0}};
            wrap_next_s = 1'b0;
        end else if (enable) begin
            acc_next_s  = sum_s[ACC_W-1:0];
            wrap_next_s = sum_s[ACC_W];
        end else begin
            acc_next_s  = acc_r;
            wrap_next_s = 1'b0;
        end
    end

`ifdef NCO_PHASE_OFFSET_EN
    logic [ACC_W-1:0] poff_act_r;

    // Active phase offset, swapped in on the same edge as the FCW.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            poff_act_r <= {ACC_W{1'b0}};
        end else if (load) begin
            poff_act_r <= poff_new;
        end else begin
            poff_act_r <= poff_act_r;
        end
    end

    assign p_s = acc_next_s + poff_act_r;
`else
    logic unused_poff_s;
    assign unused_poff_s = ^poff_new;
    assign p_s           = acc_next_s;
`endif

    // Accumulator, active FCW and output registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            acc_r     <= {ACC_W{1'b0}};
            fcw_act_r <= FCW_INIT;
            out_clk   <= 1'b0;
            wrap      <= 1'b0;
            phase     <= {OUT_W{1'b0}};
        end else begin
            acc_r     <= acc_next_s;
            fcw_act_r <= load ? fcw_new : fcw_act_r;
            out_clk   <= p_s[ACC_W-1];
            wrap      <= wrap_next_s;
            phase     <= p_s[ACC_W-1 -: OUT_W];
        end
    end
endmodule

// File: rtl/nco_multi.sv
// Multi-channel programmable NCO: shadow registers, write decode and the
// IDLE/APPLY transfer FSM. Optional phase offsets under NCO_PHASE_OFFSET_EN.
module nco_multi
    import nco_pkg::*;
#(
    parameter int          N_CH      = 4,
    parameter int          ACC_W     = 32,
    parameter int          OUT_W     = 12,
    parameter logic [31:0] FCW_RESET = FCW_RESET_DEF
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic                  sync,
    nco_multi_if.slave            cfg,
    output logic [N_CH-1:0]       out_clk,
    output logic [N_CH-1:0]       wrap,
    output logic [N_CH*OUT_W-1:0] phase
);
    localparam int               CH_W     = ch_w(N_CH);
    localparam logic [ACC_W-1:0] FCW_INIT = ACC_W'(FCW_RESET);

    logic [0:0] state_r;
    logic [0:0] state_next_s;
    logic       ready_r;
    logic       wr_go_s;
    logic       apply_go_s;

    // ready_r is only high in IDLE, so it also gates the apply request.
    assign cfg.cfg_ready = ready_r;
    assign wr_go_s       = cfg.cfg_valid & ready_r;
    assign apply_go_s    = cfg.cfg_apply & ready_r;

    // Apply FSM next state: APPLY always lasts exactly one cycle.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE:  state_next_s = apply_go_s ? ST_APPLY : ST_IDLE;
            ST_APPLY: state_next_s = ST_IDLE;
            default:  state_next_s = ST_IDLE;
        endcase
    end

    // FSM state and ready; ready stays low for the first cycle after reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
            ready_r <= 1'b0;
        end else begin
            state_r <= state_next_s;
            ready_r <= (state_next_s == ST_IDLE);
        end
    end

`ifndef NCO_PHASE_OFFSET_EN
    logic unused_poff_s;
    assign unused_poff_s = ^cfg.cfg_poff;
`endif

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic             hit_s;
        logic [ACC_W-1:0] fcw_shd_r;
        logic [ACC_W-1:0] fcw_xfer_s;
        logic [ACC_W-1:0] poff_xfer_s;

        // Out-of-range channel indices match no channel and are dropped.
        assign hit_s      = wr_go_s && (cfg.cfg_ch == CH_W'(c));
        assign fcw_xfer_s = hit_s ? cfg.cfg_fcw : fcw_shd_r;

        // FCW shadow register; the bypassed value feeds a same-cycle apply.
        always_ff @(posedge clk) begin
            if (!reset_n) begin
                fcw_shd_r <= FCW_INIT;
            end else begin
                fcw_shd_r <= fcw_xfer_s;
            end
        end

`ifdef NCO_PHASE_OFFSET_EN
        logic [ACC_W-1:0] poff_shd_r;
        assign poff_xfer_s = hit_s ? cfg.cfg_poff : poff_shd_r;

        // Phase-offset shadow register.
        always_ff @(posedge clk) begin
            if (!reset_n) begin
                poff_shd_r <= {ACC_W{1'b0}};
            end else begin
                poff_shd_r <= poff_xfer_s;
            end
        end
`else
        assign poff_xfer_s = {ACC_W{1'b0}};
`endif

        nco_channel #(
            .ACC_W    (ACC_W),
            .OUT_W    (OUT_W),
            .FCW_INIT (FCW_INIT)
        ) u_ch (
            .clk      (clk),
            .reset_n  (reset_n),
            .enable   (enable),
            .sync     (sync),
            .load     (apply_go_s),
            .fcw_new  (fcw_xfer_s),
            .poff_new (poff_xfer_s),
            .out_clk  (out_clk[c]),
            .wrap     (wrap[c]),
            .phase    (phase[c*OUT_W +: OUT_W])
        );
    end
endmodule
